// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Definitions shared by the UART transmitter and the matching receiver:
// frame state encodings, parity mode codes, the clocks-per-bit computation
// and small helpers for counter sizing and parity generation.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    // Frame states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Parity mode codes carried by C_UART_PARITY.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Clock cycles per bit; integer division truncates, so the real baud
    // rate is slightly high when the clock is not an exact multiple.
    function automatic int uart_div(input int clk_frq, input int rate);
        return clk_frq / rate;
    endfunction

    // Width of a counter that has to reach count values 0..n-1
    // (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Parity bit for a word whose XOR-reduction is ones_odd.
    // Even mode: total ones including parity is even; odd mode: odd.
    function automatic logic parity_bit(input int mode, input logic ones_odd);
        case (mode)
            PARITY_EVEN: return ones_odd;
            PARITY_ODD:  return !ones_odd;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud.sv
// -----------------------------------------------------------------------------
// uart_baud
// Free-running bit-period counter. Counts 0..C_DIV-1 and wraps; tick is high
// during the last cycle of every bit period. restart forces the count back to
// zero so a new bit period starts on the following cycle.
//
// Ports
//   clk      in   master clock, rising edge
//   rstb     in   asynchronous active-low reset
//   restart  in   synchronous restart of the bit period
//   tick     out  one-cycle pulse in the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud
    import uart_tx_pkg::*;
#(
    parameter int C_DIV = 100
) (
    input  logic clk,
    input  logic rstb,
    input  logic restart,
    output logic tick
);

    localparam int CW = cnt_width(C_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_reg <= '0;
        end else if (restart || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit, C_UART_DATA_WIDTH data bits LSB first, an
// optional even/odd parity bit and 1 or 2 stop bits. Every bit lasts
// C_CLK_FRQ / C_UART_RATE clock cycles.
//
// Ports
//   clk   in   master clock, rising edge
//   rstb  in   asynchronous active-low reset; aborts a frame, tx goes high
//   send  in   transmit request, accepted only while idle
//   data  in   word to send, sampled on the accepting edge
//   busy  out  high from the edge entering START through the last STOP cycle
//   done  out  one-cycle pulse in the first idle cycle after STOP
//   tx    out  serial line, idle high, driven straight from a flop
// -----------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int C_CLK_FRQ         = 100_000_000,
    parameter int C_UART_RATE       = 1_000_000,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_UART_PARITY     = 1,
    parameter int C_UART_STOP       = 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         send,
    input  logic [C_UART_DATA_WIDTH-1:0] data,
    output logic                         busy,
    output logic                         done,
    output logic                         tx
);

    localparam int C_DIV = uart_div(C_CLK_FRQ, C_UART_RATE);
    localparam int BW    = cnt_width(C_UART_DATA_WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(C_UART_DATA_WIDTH - 1);
    localparam logic HAS_PARITY = (C_UART_PARITY != PARITY_NONE);
    // Stop counter only ever needs to distinguish stop bit 0 from 1.
    localparam logic STOP_LAST  = (C_UART_STOP == 2);

    uart_state_t                  state_reg,   state_next;
    logic [C_UART_DATA_WIDTH-1:0] shift_reg,   shift_next;
    logic [BW-1:0]                bit_cnt_reg, bit_cnt_next;
    logic                         stop_cnt_reg, stop_cnt_next;
    logic                         parity_reg,  parity_next;
    logic                         tx_reg,      tx_next;
    logic                         busy_reg,    busy_next;
    logic                         done_reg,    done_next;

    logic baud_tick;
    logic baud_restart;

    // Hold the bit timer at zero while idle and restart it on every state
    // change, so each state lasts whole bit periods regardless of when send
    // arrived.
    assign baud_restart = (state_reg == IDLE) || (state_next != state_reg);

    uart_baud #(
        .C_DIV(C_DIV)
    ) u_baud (
        .clk     (clk),
        .rstb    (rstb),
        .restart (baud_restart),
        .tick    (baud_tick)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        parity_next   = parity_reg;

        case (state_reg)
            IDLE: begin
                if (send) begin
                    state_next    = START;
                    shift_next    = data;
                    parity_next   = parity_bit(C_UART_PARITY, ^data);
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_reg == STOP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so tx, busy
    // and done change on the same edge as the state and never glitch.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_reg == STOP) && (state_next == IDLE);
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Three transmitters share clock, reset and data: index 0 even parity/1 stop,
// index 1 odd parity/2 stop, index 2 no parity/1 stop (100 clocks per bit).
// Expected frames go into a scoreboard queue when send is driven; each
// captured waveform is compared cycle by cycle against the popped entry.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int DIV = 100;
    localparam int CAP = 2500;

    logic       clk = 1'b0;
    logic       rstb;
    logic [2:0] send_v;
    logic [7:0] data;
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    always #5 clk = ~clk;

    uart_tx #(
        .C_CLK_FRQ(100_000_000), .C_UART_RATE(1_000_000),
        .C_UART_DATA_WIDTH(8), .C_UART_PARITY(1), .C_UART_STOP(1)
    ) dut_e (
        .clk(clk), .rstb(rstb), .send(send_v[0]), .data(data),
        .busy(busy_w[0]), .done(done_w[0]), .tx(tx_w[0])
    );

    uart_tx #(
        .C_CLK_FRQ(100_000_000), .C_UART_RATE(1_000_000),
        .C_UART_DATA_WIDTH(8), .C_UART_PARITY(2), .C_UART_STOP(2)
    ) dut_o (
        .clk(clk), .rstb(rstb), .send(send_v[1]), .data(data),
        .busy(busy_w[1]), .done(done_w[1]), .tx(tx_w[1])
    );

    uart_tx #(
        .C_CLK_FRQ(100_000_000), .C_UART_RATE(1_000_000),
        .C_UART_DATA_WIDTH(8), .C_UART_PARITY(0), .C_UART_STOP(1)
    ) dut_n (
        .clk(clk), .rstb(rstb), .send(send_v[2]), .data(data),
        .busy(busy_w[2]), .done(done_w[2]), .tx(tx_w[2])
    );

    typedef struct {
        int         idx;
        logic [7:0] d;
        logic       par;   // expected parity bit (ignored without parity)
        int         len;   // expected busy length in clk cycles
    } exp_t;

    exp_t sb[$];
    exp_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;

    logic tx_cap   [0:CAP-1];
    logic busy_cap [0:CAP-1];
    logic done_cap [0:CAP-1];

    function automatic bit has_par(input int idx);
        return idx != 2;
    endfunction

    function automatic int n_stop(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Raise send for one instance at a negedge; returns at the negedge of the
    // first cycle after the accepting edge (capture index 0).
    task automatic start_send(input int idx, input logic [7:0] d, input bit hold);
        @(negedge clk);
        data        = d;
        send_v[idx] = 1'b1;
        @(negedge clk);
        if (!hold) send_v[idx] = 1'b0;
    endtask

    // Sample one instance for n cycles at negedges; up to two input changes
    // can be applied after sampling cycle k1 / k2 (use -1 for none).
    task automatic capture(input int idx, input int n,
                           input int k1, input logic [7:0] d1, input logic s1,
                           input int k2, input logic [7:0] d2, input logic s2);
        for (int k = 0; k < n; k++) begin
            tx_cap[k]   = tx_w[idx];
            busy_cap[k] = busy_w[idx];
            done_cap[k] = done_w[idx];
            if (k == k1) begin data = d1; send_v[idx] = s1; end
            if (k == k2) begin data = d2; send_v[idx] = s2; end
            @(negedge clk);
        end
    endtask

    // Pop the next expected frame and compare the capture starting at off.
    task automatic check_frame(input int off, input string tag);
        exp_t e;
        logic exp_bits [0:12];
        int   ns;
        int   cnt;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
            return;
        end
        e  = sb.pop_front();
        ns = 0;
        exp_bits[ns++] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[ns++] = e.d[i];
        if (has_par(e.idx)) exp_bits[ns++] = e.par;
        for (int j = 0; j < n_stop(e.idx); j++) exp_bits[ns++] = 1'b1;

        for (int s = 0; s < ns; s++) begin
            cnt = 0;
            for (int c = 0; c < DIV; c++)
                if (tx_cap[off + s*DIV + c] !== exp_bits[s]) cnt++;
            check($sformatf("%s tx slot %0d wrong cycles", tag, s), cnt, 0);
        end

        cnt = 0;
        for (int k = 0; k <= e.len; k++) if (busy_cap[off + k] === 1'b1) cnt++;
        check($sformatf("%s busy cycles", tag), cnt, e.len);

        cnt = 0;
        for (int k = 0; k <= e.len; k++) if (done_cap[off + k] === 1'b1) cnt++;
        check($sformatf("%s done pulses", tag), cnt, 1);
        check($sformatf("%s done position", tag), int'(done_cap[off + e.len]), 1);
        check($sformatf("%s tx idle after stop", tag), int'(tx_cap[off + e.len]), 1);
        $display("frame %s: inst %0d data 0x%02h checked", tag, e.idx, e.d);
    endtask

    initial begin
        int cnt;

        vecs[0] = '{0, 8'h55, 1'b0, 1100};
        vecs[1] = '{1, 8'h01, 1'b0, 1200};
        vecs[2] = '{2, 8'hFF, 1'b0, 1000};
        vecs[3] = '{0, 8'h80, 1'b1, 1100};
        vecs[4] = '{1, 8'h00, 1'b1, 1200};
        vecs[5] = '{2, 8'h3C, 1'b0, 1000};
        vecs[6] = '{0, 8'hF7, 1'b1, 1100};
        vecs[7] = '{1, 8'hA5, 1'b1, 1200};

        rstb   = 1'b0;
        send_v = 3'b000;
        data   = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset tx[%0d]", i),   int'(tx_w[i]),   1);
            check($sformatf("reset busy[%0d]", i), int'(busy_w[i]), 0);
            check($sformatf("reset done[%0d]", i), int'(done_w[i]), 0);
        end
        $display("reset state checked");
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames
        for (int v = 0; v < 8; v++) begin
            sb.push_back(vecs[v]);
            start_send(vecs[v].idx, vecs[v].d, 1'b0);
            capture(vecs[v].idx, vecs[v].len + 5, -1, 8'h00, 1'b0, -1, 8'h00, 1'b0);
            check_frame(0, $sformatf("vec%0d", v));
        end

        // send held high: 0xA3 then 0x3C back to back, one idle cycle between
        sb.push_back('{0, 8'hA3, 1'b0, 1100});
        sb.push_back('{0, 8'h3C, 1'b0, 1100});
        start_send(0, 8'hA3, 1'b1);
        capture(0, 2210, 0, 8'h3C, 1'b1, 1500, 8'h3C, 1'b0);
        check_frame(0, "b2b_first");
        check_frame(1101, "b2b_second");

        // data change and send pulse mid-frame are ignored
        sb.push_back('{0, 8'h69, 1'b0, 1100});
        start_send(0, 8'h69, 1'b0);
        capture(0, 1105, 300, 8'hFF, 1'b1, 301, 8'hFF, 1'b0);
        check_frame(0, "ignore");
        cnt = 0;
        for (int k = 1101; k < 1105; k++) if (busy_cap[k] === 1'b1) cnt++;
        check("ignore no second frame busy", cnt, 0);

        // reset in the middle of a frame
        start_send(0, 8'h00, 1'b0);
        capture(0, 450, -1, 8'h00, 1'b0, -1, 8'h00, 1'b0);
        check("pre-reset tx low", int'(tx_cap[449]), 0);
        rstb = 1'b0;
        #1;
        check("async reset tx", int'(tx_w[0]), 1);
        check("async reset busy", int'(busy_w[0]), 0);
        check("async reset done", int'(done_w[0]), 0);
        $display("mid-frame reset checked");
        repeat (2) @(negedge clk);
        check("reset held done", int'(done_w[0]), 0);
        // send present on the release, so the first edge with rstb high accepts
        rstb        = 1'b1;
        data        = 8'hC4;
        send_v[0]   = 1'b1;
        sb.push_back('{0, 8'hC4, 1'b1, 1100});
        @(negedge clk);
        send_v[0] = 1'b0;
        capture(0, 1105, -1, 8'h00, 1'b0, -1, 8'h00, 1'b0);
        check_frame(0, "post_reset");

        check("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
